// File: rtl/i2s_pkg.sv
// Shared types for the stereo I2S receiver: justification modes, pairing
// states and the default-width frame layout.
package i2s_pkg;

  localparam int FRAME_MAX_W = 32;
  localparam int FRAME_LEN_W = $clog2(FRAME_MAX_W + 1);

  typedef enum logic [1:0] {
    ZEXT = 2'd0,
    SEXT = 2'd1,
    MSB  = 2'd2,
    RSVD = 2'd3
  } justify_e;

  typedef enum logic {
    IDLE   = 1'b0,
    HAVE_L = 1'b1
  } pair_state_e;

  // Frame layout at the default word width; the receiver builds the same
  // layout locally sized by its own MAX_W.
  typedef struct packed {
    logic [FRAME_MAX_W-1:0] left;
    logic [FRAME_MAX_W-1:0] right;
    logic [FRAME_LEN_W-1:0] len_l;
    logic [FRAME_LEN_W-1:0] len_r;
  } frame_t;

endpackage

// File: rtl/i2s_frame_fifo.sv
// First-word-fall-through frame buffer. A push while full succeeds only if a
// pop happens in the same cycle; otherwise the push is ignored.
module i2s_frame_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_en;
  logic             rd_en;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign pop_data = mem_q[rd_ptr_q];

  // At full, a simultaneous pop frees the head slot, which the push reuses.
  always_comb begin
    wr_en    = push && (!full || pop);
    rd_en    = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/i2s_rx_stereo.sv
// Stereo I2S receiver: deserialises words, formats them, pairs left/right
// words into frames and buffers the frames for a ready/valid consumer.
module i2s_rx_stereo
  import i2s_pkg::*;
#(
  parameter int MAX_W      = 32,
  parameter int MIN_W      = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic                         SD,
  input  logic                         WS,
  input  logic [1:0]                   justify,
  input  logic                         ovf_clr,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [MAX_W-1:0]             out_left,
  output logic [MAX_W-1:0]             out_right,
  output logic [$clog2(MAX_W+1)-1:0]   out_len_l,
  output logic [$clog2(MAX_W+1)-1:0]   out_len_r,
  output logic                         overflow
);

  localparam int LW = $clog2(MAX_W + 1);

  typedef struct packed {
    logic [MAX_W-1:0] left;
    logic [MAX_W-1:0] right;
    logic [LW-1:0]    len_l;
    logic [LW-1:0]    len_r;
  } frame_w_t;

  localparam int FW = $bits(frame_w_t);

  logic             ws_d_q, ws_d_d;
  logic             iv_d_q, iv_d_d;
  logic [MAX_W-1:0] word_q, word_d;
  logic [LW-1:0]    count_q, count_d;

  logic             ev_q, ev_d;
  logic             ev_ok_q, ev_ok_d;
  logic             ev_ch_q, ev_ch_d;
  logic             ev_fall_q, ev_fall_d;
  logic [MAX_W-1:0] ev_data_q, ev_data_d;
  logic [LW-1:0]    ev_len_q, ev_len_d;

  pair_state_e      state_q, state_d;
  logic [MAX_W-1:0] held_q, held_d;
  logic [LW-1:0]    held_len_q, held_len_d;
  logic             overflow_q, overflow_d;

  logic             boundary;
  logic             fall;
  logic             word_ok;
  logic [MAX_W-1:0] mask;
  logic [MAX_W-1:0] sign_shift;
  logic [MAX_W-1:0] fmt_word;

  logic             push;
  frame_w_t         push_frame;
  logic             pop;
  logic [FW-1:0]    fifo_rd_data;
  frame_w_t         head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             drop;

  // Word assembly: the register only ever holds the current word's bits in
  // its LSBs, so bits above the count are always zero.
  always_comb begin
    ws_d_d   = WS;
    iv_d_d   = in_valid;
    fall     = iv_d_q && !in_valid;
    boundary = fall || (iv_d_q && in_valid && (WS != ws_d_q));
    word_ok  = (count_q >= LW'(MIN_W));
    word_d   = word_q;
    count_d  = count_q;
    if (boundary) begin
      if (fall) begin
        word_d  = '0;
        count_d = '0;
      end else begin
        word_d  = {{(MAX_W-1){1'b0}}, SD};
        count_d = LW'(1);
      end
    end else if (in_valid) begin
      word_d = {word_q[MAX_W-2:0], SD};
      if (count_q != LW'(MAX_W)) begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // The first-received bit sits at index count-1.
  always_comb begin
    mask       = ~({MAX_W{1'b1}} << count_q);
    sign_shift = word_q >> (count_q - LW'(1));
    case (justify_e'(justify))
      SEXT:    fmt_word = sign_shift[0] ? (word_q | ~mask) : word_q;
      MSB:     fmt_word = word_q << (LW'(MAX_W) - count_q);
      default: fmt_word = word_q;
    endcase
  end

  always_comb begin
    ev_d      = boundary && (word_ok || fall);
    ev_ok_d   = word_ok;
    ev_ch_d   = ws_d_q;
    ev_fall_d = fall;
    ev_data_d = fmt_word;
    ev_len_d  = count_q;
  end

  // A left word completed by the stream stopping has no partner coming, so it
  // goes out immediately as a left-only frame.
  always_comb begin
    push       = 1'b0;
    push_frame = '0;
    state_d    = state_q;
    held_d     = held_q;
    held_len_d = held_len_q;
    if (ev_q) begin
      if (ev_ok_q && ev_ch_q) begin
        push             = 1'b1;
        push_frame.right = ev_data_q;
        push_frame.len_r = ev_len_q;
        if (state_q == HAVE_L) begin
          push_frame.left  = held_q;
          push_frame.len_l = held_len_q;
        end
        state_d = IDLE;
      end else if (ev_ok_q) begin
        if (ev_fall_q) begin
          push             = 1'b1;
          push_frame.left  = ev_data_q;
          push_frame.len_l = ev_len_q;
          state_d          = IDLE;
        end else begin
          held_d     = ev_data_q;
          held_len_d = ev_len_q;
          state_d    = HAVE_L;
        end
      end else if (state_q == HAVE_L) begin
        push             = 1'b1;
        push_frame.left  = held_q;
        push_frame.len_l = held_len_q;
        state_d          = IDLE;
      end
    end
  end

  i2s_frame_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_frame),
    .pop       (pop),
    .pop_data  (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // A drop in the same cycle as a clear leaves the flag set.
  always_comb begin
    head       = frame_w_t'(fifo_rd_data);
    out_valid  = !fifo_empty;
    pop        = out_valid && out_ready;
    drop       = push && fifo_full && !pop;
    overflow_d = overflow_q;
    if (ovf_clr) begin
      overflow_d = 1'b0;
    end
    if (drop) begin
      overflow_d = 1'b1;
    end
    out_left  = out_valid ? head.left  : '0;
    out_right = out_valid ? head.right : '0;
    out_len_l = out_valid ? head.len_l : '0;
    out_len_r = out_valid ? head.len_r : '0;
    overflow  = overflow_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ws_d_q     <= 1'b0;
      iv_d_q     <= 1'b0;
      word_q     <= '0;
      count_q    <= '0;
      ev_q       <= 1'b0;
      ev_ok_q    <= 1'b0;
      ev_ch_q    <= 1'b0;
      ev_fall_q  <= 1'b0;
      ev_data_q  <= '0;
      ev_len_q   <= '0;
      state_q    <= IDLE;
      held_q     <= '0;
      held_len_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      ws_d_q     <= ws_d_d;
      iv_d_q     <= iv_d_d;
      word_q     <= word_d;
      count_q    <= count_d;
      ev_q       <= ev_d;
      ev_ok_q    <= ev_ok_d;
      ev_ch_q    <= ev_ch_d;
      ev_fall_q  <= ev_fall_d;
      ev_data_q  <= ev_data_d;
      ev_len_q   <= ev_len_d;
      state_q    <= state_d;
      held_q     <= held_d;
      held_len_q <= held_len_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_i2s_rx_stereo.sv
// Directed bench for i2s_rx_stereo: pairing, formatting, runts, long words,
// overflow, reset and orphan-left behaviour.
module tb_i2s_rx_stereo;

  localparam int MAX_W      = 32;
  localparam int MIN_W      = 5;
  localparam int FIFO_DEPTH = 4;
  localparam int LW         = 6;

  typedef struct packed {
    logic [31:0]   l;
    logic [31:0]   r;
    logic [LW-1:0] ll;
    logic [LW-1:0] lr;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          SD;
  logic          WS;
  logic [1:0]    justify;
  logic          ovf_clr;
  logic          out_ready;
  logic          out_valid;
  logic [31:0]   out_left;
  logic [31:0]   out_right;
  logic [LW-1:0] out_len_l;
  logic [LW-1:0] out_len_r;
  logic          overflow;

  obs_t got_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  i2s_rx_stereo #(
    .MAX_W      (MAX_W),
    .MIN_W      (MIN_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .SD        (SD),
    .WS        (WS),
    .justify   (justify),
    .ovf_clr   (ovf_clr),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_left  (out_left),
    .out_right (out_right),
    .out_len_l (out_len_l),
    .out_len_r (out_len_r),
    .overflow  (overflow)
  );

  // Record every frame the consumer takes.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      got_q.push_back({out_left, out_right, out_len_l, out_len_r});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic ws, input logic [63:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      in_valid = 1'b1;
      WS       = ws;
      SD       = val[i];
      tick();
    end
  endtask

  task automatic end_stream();
    in_valid = 1'b0;
    SD       = 1'b0;
    tick();
  endtask

  task automatic wait_frames(input int n);
    int cyc;
    cyc = 0;
    while (got_q.size() < n && cyc < 300) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; SD = 1'b0; WS = 1'b0;
    justify = 2'd0; ovf_clr = 1'b0; out_ready = 1'b0;
    tick(); tick();
    n_checks++;
    if (out_valid !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_flags: valid/ovf %b%b, required 00", out_valid, overflow);
    end
    n_checks++;
    if ({out_left, out_right, out_len_l, out_len_r} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_data: got %h %h %0d %0d, required all zero",
               out_left, out_right, out_len_l, out_len_r);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_pair(input logic [1:0] just, input obs_t exp, input string name);
    obs_t got;
    got_q.delete();
    justify = just; out_ready = 1'b1;
    send_word(1'b0, 64'hA5, 8);
    send_word(1'b1, 64'h3C, 8);
    end_stream();
    wait_frames(1);
    repeat (5) tick();
    n_checks++;
    if (got_q.size() != 1) begin
      n_fail++;
      $display("[TB] FAIL %s_count: got %0d frames, required 1", name, got_q.size());
    end
    got = (got_q.size() > 0) ? got_q.pop_front() : '0;
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s_frame: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic test_back_to_back();
    obs_t got;
    obs_t exp [2];
    exp[0] = {32'h0000_1234, 32'h0000_ABCD, 6'd16, 6'd16};
    exp[1] = {32'h0000_0F0F, 32'h0000_F0F0, 6'd16, 6'd16};
    got_q.delete();
    justify = 2'd0; out_ready = 1'b1;
    send_word(1'b0, 64'h1234, 16);
    send_word(1'b1, 64'hABCD, 16);
    send_word(1'b0, 64'h0F0F, 16);
    send_word(1'b1, 64'hF0F0, 16);
    end_stream();
    wait_frames(2);
    repeat (5) tick();
    n_checks++;
    if (got_q.size() != 2) begin
      n_fail++;
      $display("[TB] FAIL b2b_count: got %0d frames, required 2", got_q.size());
    end
    for (int k = 0; k < 2; k++) begin
      got = (got_q.size() > 0) ? got_q.pop_front() : '0;
      n_checks++;
      if (got !== exp[k]) begin
        n_fail++;
        $display("[TB] FAIL b2b_frame%0d: got %h, required %h", k, got, exp[k]);
      end
    end
  endtask

  task automatic test_runt_long();
    obs_t got;
    obs_t exp;
    exp = {32'h0, 32'hCDEF_0123, 6'd0, 6'd32};
    got_q.delete();
    justify = 2'd0; out_ready = 1'b1;
    send_word(1'b0, 64'h5, 3);
    send_word(1'b1, 64'hAB_CDEF_0123, 40);
    end_stream();
    wait_frames(1);
    repeat (5) tick();
    n_checks++;
    if (got_q.size() != 1) begin
      n_fail++;
      $display("[TB] FAIL runt_long_count: got %0d frames, required 1", got_q.size());
    end
    got = (got_q.size() > 0) ? got_q.pop_front() : '0;
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL runt_long_frame: got %h, required %h", got, exp);
    end
    send_word(1'b1, 64'h3, 4);
    end_stream();
    repeat (8) tick();
    n_checks++;
    if (got_q.size() != 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL runt_only: got %0d frames valid=%b, required 0 frames valid=0",
               got_q.size(), out_valid);
    end
  endtask

  task automatic test_overflow();
    obs_t got;
    obs_t exp;
    got_q.delete();
    justify = 2'd0; out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      send_word(1'b0, 64'h10 + 64'(k), 8);
      send_word(1'b1, 64'h20 + 64'(k), 8);
      end_stream();
      tick(); tick();
      if (k == 3) begin
        n_checks++;
        if (overflow !== 1'b0 || out_valid !== 1'b1 || out_left !== 32'h10) begin
          n_fail++;
          $display("[TB] FAIL ovf_four: ovf=%b valid=%b left=%h, required 0 1 00000010",
                   overflow, out_valid, out_left);
        end
      end
    end
    n_checks++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL ovf_set: got %b, required 1", overflow);
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL ovf_clear: got %b, required 0", overflow);
    end
    out_ready = 1'b1;
    wait_frames(4);
    repeat (5) tick();
    n_checks++;
    if (got_q.size() != 4 || out_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL ovf_drain_count: got %0d frames valid=%b, required 4 valid=0",
               got_q.size(), out_valid);
    end
    for (int k = 0; k < 4; k++) begin
      exp = {32'h10 + 32'(k), 32'h20 + 32'(k), 6'd8, 6'd8};
      got = (got_q.size() > 0) ? got_q.pop_front() : '0;
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("[TB] FAIL ovf_drain%0d: got %h, required %h", k, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid_word();
    obs_t got;
    obs_t exp;
    exp = {32'h0, 32'h77, 6'd0, 6'd8};
    got_q.delete();
    justify = 2'd0; out_ready = 1'b1;
    send_word(1'b0, 64'h5A, 8);
    send_word(1'b1, 64'hF, 4);
    rst = 1'b1; in_valid = 1'b0;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    n_checks++;
    if (got_q.size() != 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_word: got %0d frames valid=%b, required 0 frames valid=0",
               got_q.size(), out_valid);
    end
    send_word(1'b1, 64'h77, 8);
    end_stream();
    wait_frames(1);
    repeat (3) tick();
    got = (got_q.size() > 0) ? got_q.pop_front() : '0;
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL reset_held_left: got %h, required %h", got, exp);
    end
  endtask

  task automatic test_orphan_left();
    got_q.delete();
    justify = 2'd0; out_ready = 1'b0;
    send_word(1'b0, 64'hC3, 8);
    end_stream();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL orphan_t1: valid got %b, required 0", out_valid);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL orphan_t2: valid got %b, required 1", out_valid);
    end
    n_checks++;
    if ({out_left, out_right, out_len_l, out_len_r} !== {32'hC3, 32'h0, 6'd8, 6'd0}) begin
      n_fail++;
      $display("[TB] FAIL orphan_frame: got %h %h %0d %0d, required 000000c3 00000000 8 0",
               out_left, out_right, out_len_l, out_len_r);
    end
    out_ready = 1'b1;
    tick(); tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL orphan_drain: valid got %b, required 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_pair(2'd0, {32'h0000_00A5, 32'h0000_003C, 6'd8, 6'd8}, "basic");
    test_pair(2'd1, {32'hFFFF_FFA5, 32'h0000_003C, 6'd8, 6'd8}, "sext");
    test_pair(2'd2, {32'hA500_0000, 32'h3C00_0000, 6'd8, 6'd8}, "msb");
    test_pair(2'd3, {32'h0000_00A5, 32'h0000_003C, 6'd8, 6'd8}, "rsvd");
    test_back_to_back();
    test_runt_long();
    test_overflow();
    test_reset_mid_word();
    test_orphan_left();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/i2s_rx_stereo.md
I2S_RX_STEREO -- requirements
Module: i2s_rx_stereo

Interface
REQ-001 Parameter: MAX_W, 32, maximum word width captured; also the width of out_left and out_right.
REQ-002 Parameter: MIN_W, 5, shortest word accepted; shorter words are runts.
REQ-003 Parameter: FIFO_DEPTH, 4, number of stereo frames buffered; power of 2, at least 2.
REQ-004 Port: clk  in  1  single clock; all logic is on its rising edge.
REQ-005 Port: rst  in  1  reset; synchronous, active-high.
REQ-006 Port: in_valid  in  1  serial stream active.
REQ-007 Port: SD  in  1  serial data bit, MSB first.
REQ-008 Port: WS  in  1  word select; 0 = left, 1 = right.
REQ-009 Port: justify  in  2  0 = zero-extend right-justified, 1 = sign-extend, 2 = MSB-aligned, 3 = treated as 0.
REQ-010 Port: ovf_clr  in  1  clears the overflow flag.
REQ-011 Port: out_ready  in  1  consumer accepts the frame.
REQ-012 Port: out_valid  out  1  frame available.
REQ-013 Port: out_left, out_right  out  MAX_W  frame data.
REQ-014 Port: out_len_l, out_len_r  out  $clog2(MAX_W+1)  bit count of each word; 0 = word absent.
REQ-015 Port: overflow  out  1  sticky flag: a frame was dropped because the FIFO was full.

Function
REQ-016 SD, WS and in_valid are registered once as ws_d and iv_d.
- A word boundary occurs at cycle T when:
  - iv_d=1 and in_valid=0, or
  - iv_d=1, in_valid=1 and WS!=ws_d.
REQ-017 When in_valid=1 and there is no boundary, SD shifts into the word register and the bit count increments, saturating at MAX_W.
- Words longer than MAX_W keep only the most recent MAX_W bits.
REQ-018 At a WS-toggle boundary, the SD bit sampled at T becomes bit 1 of the next word (count=1).
- At an in_valid-fall boundary, the word register and count are cleared.
REQ-019 At a boundary with count<MIN_W, the word is discarded and no state other than the shift register changes.
REQ-020 A completed word's channel is ws_d. Formatting uses the justify value sampled at T:
- mode 0: word in the LSBs, zero-filled.
- mode 1: word in the LSBs, sign-extended from its first-received bit.
- mode 2: first-received bit at MAX_W-1, LSBs zero-filled.
REQ-021 Pairing state machine states:
- IDLE: no left word held.
- HAVE_L: a left word is held.
REQ-022 IDLE transitions:
- On a left word: store it, go to HAVE_L.
- On a right word: push frame {0, right} with len_l=0, stay in IDLE.
REQ-023 HAVE_L transitions:
- On a right word: push {left, right}, go to IDLE.
- On a left word: overwrite the held word, stay in HAVE_L.
- On an in_valid fall with no valid word: push {left, 0} with len_r=0, go to IDLE.
REQ-024 A push occurs at the T+1 edge.
- With the FIFO empty and out_ready=0, out_valid=1 and the frame is visible from cycle T+2.
- The FIFO is first-word-fall-through.
REQ-025 A transfer occurs on a cycle with out_valid=1 and out_ready=1.
- The next frame, or out_valid=0, appears on the following cycle.
- Data is held stable while out_valid=1 and out_ready=0.
REQ-026 A push when the FIFO is full and no pop occurs in the same cycle drops the frame and sets overflow at the next edge.
- A push and a pop in the same cycle at full both succeed.
REQ-027 overflow clears on ovf_clr=1. If a drop occurs in the same cycle as ovf_clr=1, the set wins.
REQ-028 When out_valid=0, out_left, out_right and the lengths are driven to 0.

Reset
REQ-029 With rst=1 at an edge, the following are cleared:
- out_valid=0, overflow=0, all data and length outputs 0;
- the FIFO is emptied;
- the state machine goes to IDLE;
- the word register, count, ws_d and iv_d are cleared.
REQ-030 Reset mid-word discards the partial word and any held left word. The first boundary after reset obeys REQ-016 with iv_d=0.

Structure
REQ-031 Package i2s_pkg holds:
- the justify_e enum (ZEXT, SEXT, MSB, RSVD);
- the pair_state_e enum (IDLE, HAVE_L);
- the frame struct {left, right, len_l, len_r} parametrised by MAX_W.
REQ-032 The frame FIFO is the sub-module i2s_frame_fifo, with parameters DEPTH and WIDTH and a push/pop/full/empty interface. All other logic is in i2s_rx_stereo.

Verification
REQ-033 Basic pair: MAX_W=32, justify=0, out_ready=1.
- Stimulus: WS=0 with 8 bits 0xA5, then WS=1 with 8 bits 0x3C, then in_valid=0.
- Response: a single frame with out_left=0x000000A5, out_right=0x0000003C, lengths 8/8.
REQ-034 Formatting: repeat the REQ-033 stimulus with justify=1, then with justify=2.
- justify=1: out_left=0xFFFFFFA5.
- justify=2: out_left=0xA5000000, out_right=0x3C000000.
REQ-035 Runt and long word:
- Stimulus: a 3-bit left word, then a 40-bit right word.
- Response: frame {0, last 32 bits} with len_l=0, len_r=32.
REQ-036 Overflow:
- Stimulus: out_ready=0, 5 frames; then ovf_clr pulse; then out_ready=1.
- Response: 4 frames stored, overflow=1 after the 5th; overflow=0 after the pulse; the 4 original frames drain in order.
REQ-037 Reset and orphan left:
- Stimulus 1: rst=1 mid-right-word → no frame is emitted.
- Stimulus 2: a left-only burst, then in_valid falls → frame {left, 0} with len_r=0, out_valid visible at T+2.
